// File: rtl/ram_axi_ctrl.sv
// Bridges a single-beat RAM request port onto AXI4 read/write channels.
// One transaction is in flight at a time; every handshake output comes from a flop.
module ram_axi_ctrl #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] i_ram_addr,
  input  logic        i_ram_wen,
  input  logic        i_ram_valid,
  input  logic [63:0] i_ram_wdata,
  input  logic [2:0]  i_ram_size,
  output logic        o_ram_ready,
  output logic [63:0] o_ram_rdata,
  output logic        o_ram_err,
  output logic        o_axi_awvalid,
  input  logic        i_axi_awready,
  output logic [63:0] o_axi_awaddr,
  output logic [3:0]  o_axi_awid,
  output logic [7:0]  o_axi_awlen,
  output logic [2:0]  o_axi_awsize,
  output logic [1:0]  o_axi_awburst,
  output logic        o_axi_wvalid,
  input  logic        i_axi_wready,
  output logic [63:0] o_axi_wdata,
  output logic [7:0]  o_axi_wstrb,
  output logic        o_axi_wlast,
  input  logic        i_axi_bvalid,
  output logic        o_axi_bready,
  input  logic [1:0]  i_axi_bresp,
  output logic        o_axi_arvalid,
  input  logic        i_axi_arready,
  output logic [63:0] o_axi_araddr,
  output logic [3:0]  o_axi_arid,
  output logic [7:0]  o_axi_arlen,
  output logic [2:0]  o_axi_arsize,
  output logic [1:0]  o_axi_arburst,
  input  logic        i_axi_rvalid,
  output logic        o_axi_rready,
  input  logic [63:0] i_axi_rdata,
  input  logic [1:0]  i_axi_rresp,
  input  logic        i_axi_rlast
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]  r_state;
  logic [63:0] r_addr;
  logic [2:0]  r_size;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;
  logic [63:0] r_rdata;
  logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic        r_ready, r_err;

  logic [2:0]  w_size;
  logic [7:0]  w_mask;
  logic [7:0]  w_strb;
  logic [63:0] w_wdata;
  logic [63:0] w_rdata;
  logic        w_aw_done, w_w_done;
  logic        w_unused;

  assign w_unused = i_axi_rlast;

  // Sizes 4-7 behave as a full 8-byte access.
  assign w_size  = i_ram_size[2] ? 3'd3 : i_ram_size;
  always_comb begin
    w_mask = 8'h01;
    case (w_size[1:0])
      2'd0: w_mask = 8'h01;
      2'd1: w_mask = 8'h03;
      2'd2: w_mask = 8'h0F;
      2'd3: w_mask = 8'hFF;
      default: w_mask = 8'h01;
    endcase
  end
  assign w_strb  = w_mask << i_ram_addr[2:0];
  assign w_wdata = i_ram_wdata << {i_ram_addr[2:0], 3'b000};
  assign w_rdata = i_axi_rdata >> {r_addr[2:0], 3'b000};

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign w_aw_done = !r_awvalid || i_axi_awready;
  assign w_w_done  = !r_wvalid  || i_axi_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_size    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_ram_valid) begin
            r_addr  <= i_ram_addr;
            r_size  <= w_size;
            r_wdata <= w_wdata;
            r_wstrb <= w_strb;
            if (i_ram_wen) begin
              r_state   <= S_WR_REQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= S_RD_ADDR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          if (i_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (i_axi_rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= w_rdata;
            r_err    <= |i_axi_rresp;
            r_ready  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_WR_REQ: begin
          if (r_awvalid && i_axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && i_axi_wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (i_axi_bvalid) begin
            r_bready <= 1'b0;
            r_err    <= |i_axi_bresp;
            r_ready  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ram_ready   = r_ready;
  assign o_ram_err     = r_err;
  assign o_ram_rdata   = r_rdata;
  assign o_axi_awvalid = r_awvalid;
  assign o_axi_awaddr  = r_addr;
  assign o_axi_awid    = AXI_ID;
  assign o_axi_awlen   = 8'd0;
  assign o_axi_awsize  = r_size;
  assign o_axi_awburst = 2'b01;
  assign o_axi_wvalid  = r_wvalid;
  assign o_axi_wdata   = r_wdata;
  assign o_axi_wstrb   = r_wstrb;
  assign o_axi_wlast   = r_wvalid;
  assign o_axi_bready  = r_bready;
  assign o_axi_arvalid = r_arvalid;
  assign o_axi_araddr  = r_addr;
  assign o_axi_arid    = AXI_ID;
  assign o_axi_arlen   = 8'd0;
  assign o_axi_arsize  = r_size;
  assign o_axi_arburst = 2'b01;
  assign o_axi_rready  = r_rready;

endmodule

// File: tb/tb_ram_axi_ctrl.sv
// Directed bench for ram_axi_ctrl: table of single transactions against a
// zero-wait slave, plus hand-written delayed-handshake, error and reset cases.
module tb_ram_axi_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] i_ram_addr;
  logic        i_ram_wen;
  logic        i_ram_valid;
  logic [63:0] i_ram_wdata;
  logic [2:0]  i_ram_size;
  logic        o_ram_ready;
  logic [63:0] o_ram_rdata;
  logic        o_ram_err;
  logic        o_axi_awvalid, i_axi_awready;
  logic [63:0] o_axi_awaddr;
  logic [3:0]  o_axi_awid;
  logic [7:0]  o_axi_awlen;
  logic [2:0]  o_axi_awsize;
  logic [1:0]  o_axi_awburst;
  logic        o_axi_wvalid, i_axi_wready;
  logic [63:0] o_axi_wdata;
  logic [7:0]  o_axi_wstrb;
  logic        o_axi_wlast;
  logic        i_axi_bvalid, o_axi_bready;
  logic [1:0]  i_axi_bresp;
  logic        o_axi_arvalid, i_axi_arready;
  logic [63:0] o_axi_araddr;
  logic [3:0]  o_axi_arid;
  logic [7:0]  o_axi_arlen;
  logic [2:0]  o_axi_arsize;
  logic [1:0]  o_axi_arburst;
  logic        i_axi_rvalid, o_axi_rready;
  logic [63:0] i_axi_rdata;
  logic [1:0]  i_axi_rresp;
  logic        i_axi_rlast;

  ram_axi_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_ram_addr(i_ram_addr), .i_ram_wen(i_ram_wen), .i_ram_valid(i_ram_valid),
    .i_ram_wdata(i_ram_wdata), .i_ram_size(i_ram_size),
    .o_ram_ready(o_ram_ready), .o_ram_rdata(o_ram_rdata), .o_ram_err(o_ram_err),
    .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awid(o_axi_awid), .o_axi_awlen(o_axi_awlen),
    .o_axi_awsize(o_axi_awsize), .o_axi_awburst(o_axi_awburst),
    .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wlast(o_axi_wlast),
    .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready), .i_axi_bresp(i_axi_bresp),
    .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arid(o_axi_arid), .o_axi_arlen(o_axi_arlen),
    .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst),
    .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready),
    .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp), .i_axi_rlast(i_axi_rlast)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Slave behaviour knobs and captured handshake payloads.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, b_cnt = 0;
  logic [63:0] sl_rdata = '0;
  logic [1:0]  sl_resp = 2'b00;
  logic [63:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [7:0]  cap_wstrb, cap_awlen, cap_arlen;
  logic [2:0]  cap_awsize, cap_arsize;
  logic [1:0]  cap_awburst, cap_arburst;
  logic        cap_wlast;

  logic aw_log[0:47], w_log[0:47], b_log[0:47], ar_log[0:47], rr_log[0:47];
  logic rdy_log[0:47], err_log[0:47];
  logic [63:0] got_rdata;

  typedef struct {
    string       name;
    logic        wen;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [63:0] srdata;
    logic [1:0]  resp;
    logic [63:0] exp_data;
    logic [7:0]  exp_strb;
    logic [2:0]  exp_size;
    logic        exp_err;
  } vec_t;
  vec_t vecs[8];

  always @(negedge clk) begin
    if (!rst_n) begin
      i_axi_awready = 1'b0; i_axi_wready = 1'b0; i_axi_arready = 1'b0;
      i_axi_rvalid = 1'b0;  i_axi_bvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; b_cnt = 0;
    end else begin
      i_axi_awready = o_axi_awvalid && (aw_cnt >= aw_dly);
      if (o_axi_awvalid && i_axi_awready) begin
        cap_awaddr = o_axi_awaddr; cap_awsize = o_axi_awsize;
        cap_awlen = o_axi_awlen;   cap_awburst = o_axi_awburst;
      end
      aw_cnt = o_axi_awvalid ? aw_cnt + 1 : 0;
      i_axi_wready = o_axi_wvalid && (w_cnt >= w_dly);
      if (o_axi_wvalid && i_axi_wready) begin
        cap_wdata = o_axi_wdata; cap_wstrb = o_axi_wstrb; cap_wlast = o_axi_wlast;
      end
      w_cnt = o_axi_wvalid ? w_cnt + 1 : 0;
      i_axi_arready = o_axi_arvalid && (ar_cnt >= ar_dly);
      if (o_axi_arvalid && i_axi_arready) begin
        cap_araddr = o_axi_araddr; cap_arsize = o_axi_arsize;
        cap_arlen = o_axi_arlen;   cap_arburst = o_axi_arburst;
      end
      ar_cnt = o_axi_arvalid ? ar_cnt + 1 : 0;
      i_axi_rvalid = o_axi_rready && (r_cnt >= r_dly);
      i_axi_rdata  = sl_rdata;
      i_axi_rresp  = sl_resp;
      r_cnt = o_axi_rready ? r_cnt + 1 : 0;
      i_axi_bvalid = o_axi_bready && (b_cnt >= b_dly);
      i_axi_bresp  = sl_resp;
      b_cnt = o_axi_bready ? b_cnt + 1 : 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic clear_caps();
    cap_awaddr = '1; cap_wdata = '1; cap_araddr = '1; cap_wstrb = '1;
    cap_awlen = '1; cap_arlen = '1; cap_awsize = '1; cap_arsize = '1;
    cap_awburst = '1; cap_arburst = '1; cap_wlast = 1'b0;
  endtask

  // Called at a negedge; presents a request and holds it until o_ram_ready.
  task automatic do_req(input logic wen, input logic [63:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata, output int lat);
    lat = -1;
    for (int k = 0; k < 48; k++) begin
      aw_log[k] = 1'b0; w_log[k] = 1'b0; b_log[k] = 1'b0; ar_log[k] = 1'b0;
      rr_log[k] = 1'b0; rdy_log[k] = 1'b0; err_log[k] = 1'b0;
    end
    i_ram_wen = wen; i_ram_addr = addr; i_ram_size = size; i_ram_wdata = wdata;
    i_ram_valid = 1'b1;
    for (int n = 1; n < 47 && lat < 0; n++) begin
      @(negedge clk);
      aw_log[n] = o_axi_awvalid; w_log[n] = o_axi_wvalid; b_log[n] = o_axi_bready;
      ar_log[n] = o_axi_arvalid; rr_log[n] = o_axi_rready;
      rdy_log[n] = o_ram_ready;  err_log[n] = o_ram_err;
      if (o_ram_ready) begin
        lat = n;
        got_rdata = o_ram_rdata;
        i_ram_valid = 1'b0;
      end
    end
    i_ram_valid = 1'b0;
    if (lat < 0) $display("FAIL timeout: no o_ram_ready within 46 cycles");
    else begin
      @(negedge clk);
      rdy_log[lat+1] = o_ram_ready; err_log[lat+1] = o_ram_err;
    end
  endtask

  int lat, li;
  logic stray;

  initial begin
    vecs[0] = '{"rd_034", 1'b0, 64'h8000_0004, 3'd2, 64'h0, 64'h1122_3344_5566_7788, 2'b00,
                64'h0000_0000_1122_3344, 8'h00, 3'd2, 1'b0};
    vecs[1] = '{"wr_035", 1'b1, 64'h8000_0003, 3'd0, 64'hAB, 64'h0, 2'b00,
                64'h0000_0000_AB00_0000, 8'h08, 3'd0, 1'b0};
    vecs[2] = '{"wr_full", 1'b1, 64'h10, 3'd3, 64'h0123_4567_89AB_CDEF, 64'h0, 2'b00,
                64'h0123_4567_89AB_CDEF, 8'hFF, 3'd3, 1'b0};
    vecs[3] = '{"wr_half", 1'b1, 64'h22, 3'd1, 64'hBEEF, 64'h0, 2'b00,
                64'h0000_0000_BEEF_0000, 8'h0C, 3'd1, 1'b0};
    vecs[4] = '{"rd_byte7", 1'b0, 64'h7, 3'd0, 64'h0, 64'hA1B2_C3D4_E5F6_0718, 2'b00,
                64'h0000_0000_0000_00A1, 8'h00, 3'd0, 1'b0};
    vecs[5] = '{"rd_clamp", 1'b0, 64'h0, 3'd7, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 2'b00,
                64'hDEAD_BEEF_CAFE_F00D, 8'h00, 3'd3, 1'b0};
    vecs[6] = '{"wr_clamp", 1'b1, 64'h4, 3'd5, 64'h1122_3344_5566_7788, 64'h0, 2'b00,
                64'h5566_7788_0000_0000, 8'hF0, 3'd3, 1'b0};
    vecs[7] = '{"wr_slverr", 1'b1, 64'h8, 3'd2, 64'hCAFE_BABE, 64'h0, 2'b11,
                64'h0000_0000_CAFE_BABE, 8'h0F, 3'd2, 1'b1};

    rst_n = 1'b0; i_ram_valid = 1'b0; i_ram_wen = 1'b0; i_ram_addr = '0;
    i_ram_wdata = '0; i_ram_size = '0; i_axi_rlast = 1'b1;
    i_axi_awready = 1'b0; i_axi_wready = 1'b0; i_axi_arready = 1'b0;
    i_axi_rvalid = 1'b0; i_axi_bvalid = 1'b0; i_axi_rdata = '0;
    i_axi_rresp = '0; i_axi_bresp = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid,
                       o_axi_rready, o_ram_ready, o_ram_err}, 64'h0);
    chk("reset_data", o_axi_awaddr | o_axi_wdata | {56'h0, o_axi_wstrb}, 64'h0);
    chk("axi_ids", {o_axi_awid, o_axi_arid}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      sl_rdata = vecs[i].srdata; sl_resp = vecs[i].resp;
      clear_caps();
      do_req(vecs[i].wen, vecs[i].addr, vecs[i].size, vecs[i].wdata, lat);
      li = (lat > 0) ? lat : 1;
      chk({vecs[i].name, "_lat"}, lat, 3);
      chk({vecs[i].name, "_err"}, err_log[li], vecs[i].exp_err);
      chk({vecs[i].name, "_pulse"}, {rdy_log[li+1], err_log[li+1]}, 0);
      if (vecs[i].wen) begin
        chk({vecs[i].name, "_awaddr"}, cap_awaddr, vecs[i].addr);
        chk({vecs[i].name, "_awsize"}, cap_awsize, vecs[i].exp_size);
        chk({vecs[i].name, "_wstrb"}, cap_wstrb, vecs[i].exp_strb);
        chk({vecs[i].name, "_wdata"}, cap_wdata, vecs[i].exp_data);
        chk({vecs[i].name, "_burst"}, {cap_awlen, cap_awburst, cap_wlast}, {8'h0, 2'b01, 1'b1});
      end else begin
        chk({vecs[i].name, "_araddr"}, cap_araddr, vecs[i].addr);
        chk({vecs[i].name, "_arsize"}, cap_arsize, vecs[i].exp_size);
        chk({vecs[i].name, "_rdata"}, got_rdata, vecs[i].exp_data);
        chk({vecs[i].name, "_burst"}, {cap_arlen, cap_arburst}, {8'h0, 2'b01});
      end
      $display("vector %0d %s wen=%0b addr=%h lat=%0d", i, vecs[i].name, vecs[i].wen,
               vecs[i].addr, lat);
    end

    // Write with awready immediate and wready held off four cycles.
    sl_resp = 2'b00; w_dly = 4;
    do_req(1'b1, 64'h40, 3'd3, 64'h55AA_55AA_0F0F_F0F0, lat);
    chk("dly_start", {aw_log[1], w_log[1], b_log[1]}, 3'b110);
    chk("dly_aw_drop", {aw_log[2], w_log[2], b_log[2]}, 3'b010);
    chk("dly_w_hold", {aw_log[5], w_log[5], b_log[5]}, 3'b010);
    chk("dly_bready", {aw_log[6], w_log[6], b_log[6]}, 3'b001);
    chk("dly_lat", lat, 7);
    $display("delayed-wready write lat=%0d", lat);
    w_dly = 0;

    // Read with SLVERR-style response.
    sl_resp = 2'b10; sl_rdata = 64'h1234;
    do_req(1'b0, 64'h0, 3'd3, 64'h0, lat);
    li = (lat > 0) ? lat : 1;
    chk("rerr_lat", lat, 3);
    chk("rerr_pulse", {rdy_log[li], err_log[li]}, 2'b11);
    chk("rerr_after", {rdy_log[li+1], err_log[li+1]}, 2'b00);
    $display("error-response read lat=%0d", lat);
    sl_resp = 2'b00;

    // Reset while waiting in RD_DATA, then a normal read afterwards.
    r_dly = 10;
    i_ram_wen = 1'b0; i_ram_addr = 64'h100; i_ram_size = 3'd3; i_ram_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rready", o_axi_rready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {o_axi_arvalid, o_axi_rready, o_ram_ready}, 3'b000);
    i_ram_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; r_dly = 0;
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      stray = stray | o_ram_ready;
    end
    chk("mid_no_ready", stray, 1'b0);
    sl_rdata = 64'h0F1E_2D3C_4B5A_6978;
    do_req(1'b0, 64'h18, 3'd3, 64'h0, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_rdata", got_rdata, 64'h0F1E_2D3C_4B5A_6978);
    $display("post-reset read lat=%0d rdata=%h", lat, got_rdata);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
